// File: rtl/psum_acc_quant.sv
// Accumulates per-column partial sums over a frame, then rounds, shifts, optionally ReLUs and
// saturates each column to OW bits, presented on a valid/ready output.
module psum_acc_quant #(
    parameter int unsigned COLUMN = 6,
    parameter int unsigned CW     = 16,
    parameter int unsigned AW     = 24,
    parameter int unsigned OW     = 8,
    parameter int unsigned SHW    = 5,
    parameter int unsigned CNTW   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [COLUMN*(CW+1)-1:0] psum_i,
    input  logic                     psum_valid,
    input  logic                     psum_last,
    output logic                     psum_ready,
    input  logic [SHW-1:0]           shift,
    input  logic                     relu_en,
    output logic [COLUMN*OW-1:0]     q_o,
    output logic                     q_valid,
    input  logic                     q_ready,
    output logic [CNTW-1:0]          beat_cnt
);

    typedef enum logic [1:0] {StIdle, StAcc, StOut} state_e;

    localparam logic signed [AW:0]   AccMaxW = {2'b00, {(AW-1){1'b1}}};
    localparam logic signed [AW:0]   AccMinW = {2'b11, {(AW-1){1'b0}}};
    localparam logic signed [AW:0]   QMax    = {{(AW-OW+2){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [AW:0]   QMin    = {{(AW-OW+2){1'b1}}, {(OW-1){1'b0}}};

    state_e                  state_q, state_d;
    logic signed [AW-1:0]    acc_q [COLUMN];
    logic signed [AW-1:0]    acc_d [COLUMN];
    logic [COLUMN*OW-1:0]    q_q, q_d;
    logic                    q_valid_q, q_valid_d;
    logic                    psum_ready_q, psum_ready_d;
    logic [CNTW-1:0]         beat_cnt_q, beat_cnt_d;

    logic signed [AW:0]      psum_ext [COLUMN];
    logic signed [AW:0]      tot      [COLUMN];
    logic signed [AW-1:0]    sum      [COLUMN];
    logic                    accept, finish;

    // Round half up, arithmetic shift in AW+1 bits, optional ReLU, clamp to OW.
    function automatic logic [OW-1:0] quant(input logic signed [AW-1:0] s_in,
                                            input logic [SHW-1:0] sh, input logic relu);
        logic signed [AW:0] r;
        logic signed [AW:0] half;
        int unsigned        s;
        s = {{(32-SHW){1'b0}}, sh};
        if (s > AW) s = AW;
        r = {s_in[AW-1], s_in};
        if (s != 0) begin
            half = (AW+1)'(1) << (s - 1);
            r    = (r + half) >>> s;
        end
        if (relu && r[AW]) r = '0;
        if (r > QMax) r = QMax;
        else if (r < QMin) r = QMin;
        return r[OW-1:0];
    endfunction

    assign accept = psum_valid & psum_ready_q;

    always_comb begin
        for (int c = 0; c < COLUMN; c++) begin
            psum_ext[c] = (AW+1)'($signed(psum_i[c*(CW+1) +: CW+1]));
            tot[c]      = {acc_q[c][AW-1], acc_q[c]} + psum_ext[c];
            if (state_q == StAcc) begin
                if (tot[c] > AccMaxW)      sum[c] = AccMaxW[AW-1:0];
                else if (tot[c] < AccMinW) sum[c] = AccMinW[AW-1:0];
                else                       sum[c] = tot[c][AW-1:0];
            end else begin
                sum[c] = psum_ext[c][AW-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        q_d        = q_q;
        q_valid_d  = q_valid_q;
        beat_cnt_d = beat_cnt_q;
        finish     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    beat_cnt_d = CNTW'(1);
                    if (psum_last) begin
                        finish = 1'b1;
                    end else begin
                        acc_d   = sum;
                        state_d = StAcc;
                    end
                end
            end
            StAcc: begin
                if (accept) begin
                    beat_cnt_d = (beat_cnt_q == '1) ? beat_cnt_q : beat_cnt_q + CNTW'(1);
                    if (psum_last) finish = 1'b1;
                    else           acc_d  = sum;
                end
            end
            StOut: begin
                if (q_ready) begin
                    q_valid_d = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (finish) begin
            for (int c = 0; c < COLUMN; c++) begin
                q_d[c*OW +: OW] = quant(sum[c], shift, relu_en);
                acc_d[c]        = '0;
            end
            q_valid_d = 1'b1;
            state_d   = StOut;
        end
        psum_ready_d = (state_d != StOut);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            q_q          <= '0;
            q_valid_q    <= 1'b0;
            psum_ready_q <= 1'b0;
            beat_cnt_q   <= '0;
            for (int c = 0; c < COLUMN; c++) acc_q[c] <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            q_q          <= q_d;
            q_valid_q    <= q_valid_d;
            psum_ready_q <= psum_ready_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    assign q_o        = q_q;
    assign q_valid    = q_valid_q;
    assign psum_ready = psum_ready_q;
    assign beat_cnt   = beat_cnt_q;

endmodule

// File: tb/tb_psum_acc_quant.sv
// Randomized and directed bench for psum_acc_quant against an arithmetic frame model.
module tb_psum_acc_quant;
    localparam int COLUMN = 6;
    localparam int CW     = 16;
    localparam int AW     = 24;
    localparam int OW     = 8;
    localparam int SHW    = 5;
    localparam int CNTW   = 8;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [COLUMN*(CW+1)-1:0] psum_i;
    logic                     psum_valid, psum_last, psum_ready;
    logic [SHW-1:0]           shift;
    logic                     relu_en;
    logic [COLUMN*OW-1:0]     q_o;
    logic                     q_valid, q_ready;
    logic [CNTW-1:0]          beat_cnt;

    int     checks = 0;
    int     errors = 0;
    longint cur_v   [COLUMN];
    longint fixed_v [COLUMN];

    psum_acc_quant #(
        .COLUMN(COLUMN), .CW(CW), .AW(AW), .OW(OW), .SHW(SHW), .CNTW(CNTW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .psum_i(psum_i), .psum_valid(psum_valid),
        .psum_last(psum_last), .psum_ready(psum_ready), .shift(shift), .relu_en(relu_en),
        .q_o(q_o), .q_valid(q_valid), .q_ready(q_ready), .beat_cnt(beat_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint clamp(input longint v, input longint lo, input longint hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    // Reference: round half up, arithmetic shift, ReLU, clamp to the output range.
    function automatic longint model_q(input longint sum, input int shf, input bit relu);
        int     s;
        longint r;
        s = (shf > AW) ? AW : shf;
        r = (s == 0) ? sum : (sum + (longint'(1) <<< (s - 1))) >>> s;
        if (relu && r < 0) r = 0;
        return clamp(r, -(longint'(1) <<< (OW - 1)), (longint'(1) <<< (OW - 1)) - 1);
    endfunction

    task automatic drive_beat(input bit last, input int shf);
        int w;
        @(negedge clk);
        for (int c = 0; c < COLUMN; c++) psum_i[c*(CW+1) +: CW+1] = cur_v[c][CW:0];
        psum_valid = 1'b1;
        psum_last  = last;
        shift      = SHW'(shf);
        w = 0;
        while (!psum_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) check("ready_wait", 0, 1);
        @(posedge clk);
    endtask

    // kind: 0 random lanes, 1 lane c = c+1, 2 fixed_v
    task automatic run_frame(input int n, input int kind, input int shf, input bit relu,
                             input int hold, input bit noisy);
        longint               macc [COLUMN];
        logic [COLUMN*OW-1:0] exp_pack;
        longint               t;
        int                   exp_cnt;
        relu_en = relu;
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c < COLUMN; c++) begin
                if (kind == 0)      cur_v[c] = longint'($urandom_range(0, 131071)) - 65536;
                else if (kind == 1) cur_v[c] = c + 1;
                else                cur_v[c] = fixed_v[c];
                macc[c] = (b == 0) ? cur_v[c] :
                          clamp(macc[c] + cur_v[c], -(longint'(1) <<< (AW - 1)),
                                (longint'(1) <<< (AW - 1)) - 1);
            end
            // shift is only meaningful on the last beat
            drive_beat(b == n - 1, (b == n - 1) ? shf : int'($urandom_range(0, 31)));
        end
        for (int c = 0; c < COLUMN; c++) begin
            t = model_q(macc[c], shf, relu);
            exp_pack[c*OW +: OW] = t[OW-1:0];
        end
        exp_cnt = (n > 255) ? 255 : n;
        @(negedge clk);
        psum_valid = 1'b0;
        relu_en    = ~relu;
        shift      = SHW'($urandom_range(0, 31));
        check("q_valid_set", longint'(q_valid), 1);
        check("ready_low_out", longint'(psum_ready), 0);
        check("q_o", longint'(q_o), longint'(exp_pack));
        check("beat_cnt", longint'(beat_cnt), exp_cnt);
        for (int h = 0; h < hold; h++) begin
            q_ready = 1'b0;
            if (noisy) begin
                for (int c = 0; c < COLUMN; c++) psum_i[c*(CW+1) +: CW+1] = 17'd50;
                psum_valid = 1'b1;
                psum_last  = 1'b0;
            end
            @(negedge clk);
            check("q_hold", longint'(q_o), longint'(exp_pack));
            check("q_valid_hold", longint'(q_valid), 1);
            check("ready_hold", longint'(psum_ready), 0);
            check("cnt_hold", longint'(beat_cnt), exp_cnt);
        end
        q_ready = 1'b1;
        @(negedge clk);
        q_ready    = 1'b0;
        psum_valid = 1'b0;
        check("q_valid_clr", longint'(q_valid), 0);
        check("ready_after_out", longint'(psum_ready), 1);
    endtask

    initial begin
        rst_n      = 1'b0;
        psum_i     = '0;
        psum_valid = 1'b0;
        psum_last  = 1'b0;
        shift      = '0;
        relu_en    = 1'b0;
        q_ready    = 1'b0;
        #12;
        check("rst_q_valid", longint'(q_valid), 0);
        check("rst_q_o", longint'(q_o), 0);
        check("rst_ready", longint'(psum_ready), 0);
        check("rst_cnt", longint'(beat_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", longint'(psum_ready), 0);
        @(negedge clk);
        check("ready_after_edge", longint'(psum_ready), 1);

        // 3 beats of c+1, held under backpressure
        run_frame(3, 1, 0, 1'b0, 5, 1'b0);

        // Rounding and ReLU on a single beat
        fixed_v = '{6, -6, 5, 0, 0, 0};
        run_frame(1, 2, 2, 1'b0, 1, 1'b0);
        run_frame(1, 2, 2, 1'b1, 0, 1'b0);

        // Output and accumulator saturation
        fixed_v = '{65535, -65536, 0, 0, 0, 0};
        run_frame(3, 2, 0, 1'b0, 0, 1'b0);
        fixed_v = '{65535, 0, 0, 0, 0, 0};
        run_frame(130, 2, 23, 1'b0, 0, 1'b0);

        // Beat counter saturates
        run_frame(300, 1, 5, 1'b0, 0, 1'b0);

        // Reset mid-frame discards the partial sums
        cur_v = '{100, 0, 0, 0, 0, 0};
        drive_beat(1'b0, 0);
        drive_beat(1'b0, 0);
        @(negedge clk);
        psum_valid = 1'b0;
        rst_n      = 1'b0;
        #1;
        check("abort_q_valid", longint'(q_valid), 0);
        check("abort_cnt", longint'(beat_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        fixed_v = '{7, 0, 0, 0, 0, 0};
        run_frame(1, 2, 0, 1'b0, 0, 1'b0);

        // Beats offered while the output is pending are ignored
        fixed_v = '{9, 9, 9, 9, 9, 9};
        run_frame(1, 2, 0, 1'b0, 3, 1'b1);
        run_frame(1, 2, 0, 1'b0, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_frame(int'($urandom_range(1, 8)), 0, int'($urandom_range(0, 31)),
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
